// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit.
// Moore FSM sequencing fetch, decode, memory, ALU and write-back steps for a
// small MIPS-like subset (add/sub/and/or/slt, lw, sw, beq, addi, j).
// Moore outputs are registered from the next state. A few strobes are
// combinational on top of that:
//   ir_we and pc_we on the FETCH ack,
//   pc_we from zero in BEQ,
//   illegal from the opcode in DECODE.
// A request timer guards every memory wait and parks the FSM in ERR on
// expiry.
//
//   state  | code | meaning
//   BOOT   |  14  | post-reset idle cycle, all outputs low
//   FETCH  |   0  | read instruction at PC, PC <= PC + 4 on ack
//   DECODE |   1  | branch target precompute, dispatch on opcode
//   MEMADR |   2  | effective address A + sign-extended imm
//   MEMRD  |   3  | load data read, wait for ack
//   MEMWB  |   4  | load data into rt
//   MEMWR  |   5  | store write, wait for ack
//   RTEX   |   6  | R-type ALU operation
//   RTWB   |   7  | R-type result into rd
//   BEQ    |   8  | compare A/B, PC <= target when equal
//   ADDIEX |   9  | A + sign-extended imm
//   ADDIWB |  10  | addi result into rt
//   JUMP   |  11  | PC <= jump address
//   ERR    |  15  | memory timeout, sticky until reset
module multicycle_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       reg_dst,
   output logic       reg_we,
   output logic       mem_to_reg,
   output logic       illegal,
   output logic       err,
   output logic [3:0] state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQ    = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_BOOT   = 4'd14,
      S_ERR    = 4'd15
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       reg_dst;
      logic       reg_we;
      logic       mem_to_reg;
      logic       err;
   } outs_t;

   state_t        cur_st;
   state_t        state_nxt;
   outs_t         outs_q;
   logic [CW-1:0] tmo_cnt;
   logic          req_st;
   logic          tmo_hit;
   logic          instr_ok;

   function automatic logic funct_ok(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
             (f == FN_OR)  || (f == FN_SLT);
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      logic [2:0] op;
      case (f)
         FN_SUB:  op = ALU_SUB;
         FN_AND:  op = ALU_AND;
         FN_OR:   op = ALU_OR;
         FN_SLT:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic is_req(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

   // Moore output image of a state; f only matters for RTEX, and the
   // instruction register is stable by the DECODE -> RTEX edge.
   function automatic outs_t moore_outs(input state_t s, input logic [5:0] f);
      outs_t o;
      o = '0;
      case (s)
         S_FETCH: begin
            o.mem_req   = 1'b1;
            o.alu_src_b = 2'b01;
            o.alu_op    = ALU_ADD;
         end
         S_DECODE: begin
            o.alu_src_b = 2'b11;
            o.alu_op    = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'b10;
            o.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            o.mem_req = 1'b1;
            o.iord    = 1'b1;
         end
         S_MEMWB: begin
            o.reg_we     = 1'b1;
            o.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            o.mem_req = 1'b1;
            o.mem_we  = 1'b1;
            o.iord    = 1'b1;
         end
         S_RTEX: begin
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'b00;
            o.alu_op    = funct_alu(f);
         end
         S_RTWB: begin
            o.reg_we  = 1'b1;
            o.reg_dst = 1'b1;
         end
         S_BEQ: begin
            o.alu_src_a = 1'b1;
            o.alu_src_b = 2'b00;
            o.alu_op    = ALU_SUB;
            o.pc_src    = 2'b01;
         end
         S_ADDIWB: begin
            o.reg_we = 1'b1;
         end
         S_JUMP: begin
            o.pc_src = 2'b10;
            o.pc_we  = 1'b1;
         end
         S_ERR: begin
            o.err = 1'b1;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

   assign req_st  = is_req(cur_st);
   // Ack in the last allowed request cycle still completes the access.
   assign tmo_hit = req_st && !mem_ack && (tmo_cnt == CW'(TIMEOUT - 1));

   // Instruction legality for the DECODE dispatch and the illegal strobe.
   always_comb begin
      instr_ok = 1'b0;
      case (opcode)
         OP_RTYPE:                       instr_ok = funct_ok(funct);
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: instr_ok = 1'b1;
         default:                        instr_ok = 1'b0;
      endcase
   end

   // Next-state selection.
   always_comb begin
      state_nxt = cur_st;
      case (cur_st)
         S_BOOT:   state_nxt = S_FETCH;
         S_FETCH: begin
            if (mem_ack)      state_nxt = S_DECODE;
            else if (tmo_hit) state_nxt = S_ERR;
         end
         S_DECODE: begin
            if (!instr_ok) state_nxt = S_FETCH;
            else begin
               case (opcode)
                  OP_RTYPE:     state_nxt = S_RTEX;
                  OP_LW, OP_SW: state_nxt = S_MEMADR;
                  OP_BEQ:       state_nxt = S_BEQ;
                  OP_ADDI:      state_nxt = S_ADDIEX;
                  OP_J:         state_nxt = S_JUMP;
                  default:      state_nxt = S_FETCH;
               endcase
            end
         end
         S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (mem_ack)      state_nxt = S_MEMWB;
            else if (tmo_hit) state_nxt = S_ERR;
         end
         S_MEMWB:  state_nxt = S_FETCH;
         S_MEMWR: begin
            if (mem_ack)      state_nxt = S_FETCH;
            else if (tmo_hit) state_nxt = S_ERR;
         end
         S_RTEX:   state_nxt = S_RTWB;
         S_RTWB:   state_nxt = S_FETCH;
         S_BEQ:    state_nxt = S_FETCH;
         S_ADDIEX: state_nxt = S_ADDIWB;
         S_ADDIWB: state_nxt = S_FETCH;
         S_JUMP:   state_nxt = S_FETCH;
         S_ERR:    state_nxt = S_ERR;
         default:  state_nxt = S_BOOT;
      endcase
   end

   // State, registered Moore outputs and request timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_st  <= S_BOOT;
         outs_q  <= '0;
         tmo_cnt <= '0;
      end else begin
         cur_st <= state_nxt;
         outs_q <= moore_outs(state_nxt, funct);
         if (is_req(state_nxt) && (state_nxt != cur_st))
            tmo_cnt <= '0;
         else if (req_st && !mem_ack)
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign mem_req    = outs_q.mem_req;
   assign mem_we     = outs_q.mem_we;
   assign iord       = outs_q.iord;
   assign pc_src     = outs_q.pc_src;
   assign alu_src_a  = outs_q.alu_src_a;
   assign alu_src_b  = outs_q.alu_src_b;
   assign alu_op     = outs_q.alu_op;
   assign reg_dst    = outs_q.reg_dst;
   assign reg_we     = outs_q.reg_we;
   assign mem_to_reg = outs_q.mem_to_reg;
   assign err        = outs_q.err;
   assign state      = cur_st;

   assign ir_we   = (cur_st == S_FETCH) && mem_ack;
   assign pc_we   = outs_q.pc_we || ir_we || ((cur_st == S_BEQ) && zero);
   assign illegal = (cur_st == S_DECODE) && !instr_ok;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction flows, memory waits,
// timeout, and asynchronous reset.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ack;
   logic       mem_req, mem_we, iord, ir_we, pc_we;
   logic [1:0] pc_src, alu_src_b;
   logic       alu_src_a, reg_dst, reg_we, mem_to_reg, illegal, err;
   logic [2:0] alu_op;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;

   multicycle_ctrl #(.TIMEOUT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ack    (mem_ack),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .reg_dst    (reg_dst),
      .reg_we     (reg_we),
      .mem_to_reg (mem_to_reg),
      .illegal    (illegal),
      .err        (err),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      mem_ack = 1'b1;
      opcode  = 6'b000000;
      funct   = 6'b100000;
      zero    = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_state",   32'(state),   32'd14);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_ir_we",   32'(ir_we),   32'd0);
      check("rst_pc_we",   32'(pc_we),   32'd0);

      // add: 14,0,1,6,7,0
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("boot_state",   32'(state),   32'd14);
      check("boot_mem_req", 32'(mem_req), 32'd0);
      step();
      check("add_fetch_state", 32'(state),     32'd0);
      check("fetch_mem_req",   32'(mem_req),   32'd1);
      check("fetch_iord",      32'(iord),      32'd0);
      check("fetch_alu_b",     32'(alu_src_b), 32'd1);
      check("fetch_ir_we",     32'(ir_we),     32'd1);
      check("fetch_pc_we",     32'(pc_we),     32'd1);
      step();
      check("add_decode_state", 32'(state),     32'd1);
      check("decode_alu_b",     32'(alu_src_b), 32'd3);
      check("decode_illegal",   32'(illegal),   32'd0);
      step();
      check("add_rtex_state", 32'(state),     32'd6);
      check("add_alu_op",     32'(alu_op),    32'd0);
      check("rtex_alu_a",     32'(alu_src_a), 32'd1);
      check("rtex_alu_b",     32'(alu_src_b), 32'd0);
      step();
      check("add_rtwb_state", 32'(state),   32'd7);
      check("rtwb_reg_we",    32'(reg_we),  32'd1);
      check("rtwb_reg_dst",   32'(reg_dst), 32'd1);
      step();
      check("add_back_fetch", 32'(state), 32'd0);

      // slt
      funct = 6'b101010;
      step();
      step();
      check("slt_rtex_state", 32'(state),  32'd6);
      check("slt_alu_op",     32'(alu_op), 32'd4);
      step();
      step();
      check("slt_back_fetch", 32'(state), 32'd0);

      // lw with three wait cycles in MEMRD
      opcode = 6'b100011;
      step();
      step();
      check("lw_memadr_state", 32'(state),     32'd2);
      check("memadr_alu_a",    32'(alu_src_a), 32'd1);
      check("memadr_alu_b",    32'(alu_src_b), 32'd2);
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 3) mem_ack = 1'b1;
         #1;
         check("lw_memrd_state", 32'(state),   32'd3);
         check("lw_memrd_req",   32'(mem_req), 32'd1);
         check("lw_memrd_iord",  32'(iord),    32'd1);
      end
      step();
      check("lw_memwb_state",  32'(state),      32'd4);
      check("memwb_reg_we",    32'(reg_we),     32'd1);
      check("memwb_mem2reg",   32'(mem_to_reg), 32'd1);
      check("memwb_reg_dst",   32'(reg_dst),    32'd0);
      check("memwb_mem_req",   32'(mem_req),    32'd0);
      step();
      check("lw_back_fetch", 32'(state), 32'd0);

      // beq taken then not taken
      opcode = 6'b000100;
      zero   = 1'b1;
      step();
      step();
      check("beq1_state",  32'(state),  32'd8);
      check("beq1_pc_src", 32'(pc_src), 32'd1);
      check("beq1_pc_we",  32'(pc_we),  32'd1);
      check("beq1_alu_op", 32'(alu_op), 32'd1);
      step();
      check("beq1_back_fetch", 32'(state), 32'd0);
      zero = 1'b0;
      step();
      step();
      check("beq0_state",  32'(state),  32'd8);
      check("beq0_pc_src", 32'(pc_src), 32'd1);
      check("beq0_pc_we",  32'(pc_we),  32'd0);
      step();
      check("beq0_back_fetch", 32'(state), 32'd0);

      // j
      opcode = 6'b000010;
      step();
      step();
      check("jump_state",  32'(state),  32'd11);
      check("jump_pc_src", 32'(pc_src), 32'd2);
      check("jump_pc_we",  32'(pc_we),  32'd1);
      step();
      check("jump_back_fetch", 32'(state), 32'd0);

      // sw, reset while waiting in MEMWR
      opcode = 6'b101011;
      step();
      step();
      check("sw_memadr_state", 32'(state), 32'd2);
      mem_ack = 1'b0;
      step();
      check("sw_memwr_state", 32'(state),   32'd5);
      check("memwr_mem_req",  32'(mem_req), 32'd1);
      check("memwr_mem_we",   32'(mem_we),  32'd1);
      check("memwr_iord",     32'(iord),    32'd1);
      step();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_state",   32'(state),   32'd14);
      check("midrst_mem_req", 32'(mem_req), 32'd0);
      check("midrst_mem_we",  32'(mem_we),  32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("rerel_boot", 32'(state), 32'd14);
      step();
      check("rerel_fetch", 32'(state), 32'd0);

      // ack arriving in the 16th request cycle still wins; then illegal op
      opcode = 6'b111111;
      for (int i = 0; i < 15; i++) begin
         check("late_ack_wait", 32'(state), 32'd0);
         step();
      end
      mem_ack = 1'b1;
      #1;
      check("late_ack_state", 32'(state), 32'd0);
      check("late_ack_ir_we", 32'(ir_we), 32'd1);
      step();
      mem_ack = 1'b0;
      #1;
      check("ill_decode_state", 32'(state),   32'd1);
      check("ill_pulse",        32'(illegal), 32'd1);
      check("ill_reg_we",       32'(reg_we),  32'd0);
      check("ill_mem_we",       32'(mem_we),  32'd0);
      step();
      check("ill_back_fetch", 32'(state),   32'd0);
      check("ill_pulse_gone", 32'(illegal), 32'd0);

      // timeout in FETCH
      for (int i = 0; i < 16; i++) begin
         check("tmo_fetch_state", 32'(state),   32'd0);
         check("tmo_mem_req",     32'(mem_req), 32'd1);
         step();
      end
      check("tmo_err_state", 32'(state),   32'd15);
      check("tmo_err",       32'(err),     32'd1);
      check("tmo_mem_req_0", 32'(mem_req), 32'd0);
      mem_ack = 1'b1;
      step();
      step();
      check("err_hold_state", 32'(state), 32'd15);
      check("err_hold_err",   32'(err),   32'd1);
      check("err_hold_ir_we", 32'(ir_we), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("err_rst_state", 32'(state), 32'd14);
      check("err_rst_err",   32'(err),   32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
